// File: rtl/memory_access_unit.sv
// Memory-access pipeline stage: registers execute results, runs the
// data-memory request/grant/response handshake with byte-lane steering
// and load extension, and supplies the MA forwarding operand and stall.

package multicore_pkg;
    parameter int DATA_SIZE = 32;

    typedef enum logic [2:0] {
        LDOP_LB  = 3'd0,
        LDOP_LH  = 3'd1,
        LDOP_LW  = 3'd2,
        LDOP_LBU = 3'd3,
        LDOP_LHU = 3'd4
    } t_ldop;

    typedef enum logic [1:0] {
        SOP_SB = 2'd0,
        SOP_SH = 2'd1,
        SOP_SW = 2'd2
    } t_sop;
endpackage

module memory_access_unit #(
    parameter int DATA_SIZE   = multicore_pkg::DATA_SIZE,
    parameter int NUM_REGS    = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                        i_aclk,
    input  logic                        i_areset_n,
    input  logic                        i_en,
    input  logic                        i_flush,
    input  logic [DATA_SIZE-1:0]        i_exe_calc,
    input  logic [DATA_SIZE-1:0]        i_exe_wdata,
    input  logic [DATA_SIZE-1:0]        i_pcplus4,
    input  logic [$clog2(NUM_REGS)-1:0] i_rdest,
    input  logic                        i_cu_regwrite,
    input  logic                        i_cu_memwrite,
    input  logic                        i_cu_memaccess,
    input  logic [1:0]                  i_cu_memtoreg,
    input  multicore_pkg::t_ldop        i_ldop,
    input  multicore_pkg::t_sop         i_sop,
    output logic [$clog2(NUM_REGS)-1:0] o_rdest,
    output logic                        o_cu_regwrite,
    output logic [1:0]                  o_cu_memtoreg,
    output logic [DATA_SIZE-1:0]        o_exe_calc,
    output logic [DATA_SIZE-1:0]        o_pcplus4,
    output logic [DATA_SIZE-1:0]        o_mem_rdata,
    output logic [DATA_SIZE-1:0]        o_ma_op,
    output logic                        o_stall,
    output logic                        o_misaligned,
    output logic                        o_bus_err,
    output logic                        o_dmem_req,
    output logic                        o_dmem_we,
    output logic [DATA_SIZE-1:0]        o_dmem_addr,
    output logic [DATA_SIZE-1:0]        o_dmem_wdata,
    output logic [3:0]                  o_dmem_be,
    input  logic                        i_dmem_gnt,
    input  logic                        i_dmem_rvalid,
    input  logic [DATA_SIZE-1:0]        i_dmem_rdata
);

    localparam int RW = $clog2(NUM_REGS);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } t_state;

    t_state                r_state;
    t_state                w_state_nxt;

    logic [RW-1:0]         r_rdest;
    logic                  r_regwrite;
    logic                  r_memwrite;
    logic [1:0]            r_memtoreg;
    logic [DATA_SIZE-1:0]  r_exe_calc;
    logic [DATA_SIZE-1:0]  r_pcplus4;
    multicore_pkg::t_ldop  r_ldop;
    logic [DATA_SIZE-1:0]  r_mem_rdata;
    logic                  r_misaligned;
    logic                  r_bus_err;
    logic                  r_dmem_req;
    logic                  r_dmem_we;
    logic [DATA_SIZE-1:0]  r_dmem_addr;
    logic [DATA_SIZE-1:0]  r_dmem_wdata;
    logic [3:0]            r_dmem_be;
    logic [TW-1:0]         r_tmo;

    logic                  w_capture;
    logic                  w_regwrite_in;
    logic                  w_memwrite_in;
    logic                  w_memaccess_in;
    logic                  w_half;
    logic                  w_word;
    logic                  w_misalign;
    logic                  w_issue;
    logic                  w_tmo;
    logic                  w_tmo_fire;
    logic                  w_req_done;
    logic                  w_load_done;
    logic [3:0]            w_be;
    logic [DATA_SIZE-1:0]  w_wdata;
    logic [DATA_SIZE-1:0]  w_shifted;
    logic [DATA_SIZE-1:0]  w_ld_ext;

    // A stalled stage holds everything; a flush only turns a fresh capture into a bubble.
    assign w_capture      = i_en & ~o_stall;
    assign w_regwrite_in  = i_cu_regwrite  & ~i_flush;
    assign w_memwrite_in  = i_cu_memwrite  & ~i_flush;
    assign w_memaccess_in = i_cu_memaccess & ~i_flush;

    assign w_half = w_memwrite_in ? (i_sop == multicore_pkg::SOP_SH)
                                  : (i_ldop == multicore_pkg::LDOP_LH || i_ldop == multicore_pkg::LDOP_LHU);
    assign w_word = w_memwrite_in ? (i_sop == multicore_pkg::SOP_SW)
                                  : (i_ldop == multicore_pkg::LDOP_LW);

    assign w_misalign = w_memaccess_in & ((w_half & i_exe_calc[0]) | (w_word & (|i_exe_calc[1:0])));
    assign w_issue    = w_capture & w_memaccess_in & ~w_misalign;

    // The increment taken in this cycle would bring the counter to TIMEOUT_CYC.
    assign w_tmo = (r_tmo == TW'(TIMEOUT_CYC - 1));

    // Store lane steering: replicate the data so the enabled lanes carry it.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = i_exe_wdata;
        if (w_memwrite_in) begin
            case (i_sop)
                multicore_pkg::SOP_SB: begin
                    w_be    = 4'b0001 << i_exe_calc[1:0];
                    w_wdata = {4{i_exe_wdata[7:0]}};
                end
                multicore_pkg::SOP_SH: begin
                    w_be    = i_exe_calc[1] ? 4'b1100 : 4'b0011;
                    w_wdata = {2{i_exe_wdata[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = i_exe_wdata;
                end
            endcase
        end
    end

    // Load extraction: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        w_shifted = i_dmem_rdata >> {r_exe_calc[1:0], 3'b000};
        w_ld_ext  = w_shifted;
        case (r_ldop)
            multicore_pkg::LDOP_LB:  w_ld_ext = {{(DATA_SIZE-8){w_shifted[7]}}, w_shifted[7:0]};
            multicore_pkg::LDOP_LH:  w_ld_ext = {{(DATA_SIZE-16){w_shifted[15]}}, w_shifted[15:0]};
            multicore_pkg::LDOP_LBU: w_ld_ext = {{(DATA_SIZE-8){1'b0}}, w_shifted[7:0]};
            multicore_pkg::LDOP_LHU: w_ld_ext = {{(DATA_SIZE-16){1'b0}}, w_shifted[15:0]};
            default:                 w_ld_ext = i_dmem_rdata;
        endcase
    end

    // Bus FSM state register.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Bus FSM next state; a completing handshake wins over a same-cycle timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_tmo_fire  = 1'b0;
        w_req_done  = 1'b0;
        w_load_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_issue) w_state_nxt = S_REQ;
            end
            S_REQ: begin
                if (i_dmem_gnt) begin
                    w_req_done  = 1'b1;
                    w_state_nxt = r_memwrite ? S_IDLE : S_WAIT;
                end else if (w_tmo) begin
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (i_dmem_rvalid) begin
                    w_load_done = 1'b1;
                    w_state_nxt = S_IDLE;
                end else if (w_tmo) begin
                    w_tmo_fire  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Pipeline registers for write-back; regwrite is killed by misalignment or bus error.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_rdest    <= '0;
            r_regwrite <= 1'b0;
            r_memwrite <= 1'b0;
            r_memtoreg <= 2'b00;
            r_exe_calc <= '0;
            r_pcplus4  <= '0;
            r_ldop     <= multicore_pkg::LDOP_LB;
        end else if (w_capture) begin
            r_rdest    <= i_rdest;
            r_regwrite <= w_regwrite_in & ~w_misalign;
            r_memwrite <= w_memwrite_in;
            r_memtoreg <= i_cu_memtoreg;
            r_exe_calc <= i_exe_calc;
            r_pcplus4  <= i_pcplus4;
            r_ldop     <= i_ldop;
        end else if (w_tmo_fire) begin
            r_regwrite <= 1'b0;
        end
    end

    // Single-cycle error pulses.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_misaligned <= 1'b0;
            r_bus_err    <= 1'b0;
        end else begin
            r_misaligned <= w_capture & w_misalign;
            r_bus_err    <= w_tmo_fire;
        end
    end

    // Registered bus request, held stable from issue until grant or timeout.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_addr  <= '0;
            r_dmem_wdata <= '0;
            r_dmem_be    <= 4'b0000;
        end else if (w_issue) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= w_memwrite_in;
            r_dmem_addr  <= {i_exe_calc[DATA_SIZE-1:2], 2'b00};
            r_dmem_wdata <= w_wdata;
            r_dmem_be    <= w_be;
        end else if (w_req_done || w_tmo_fire) begin
            r_dmem_req   <= 1'b0;
            r_dmem_we    <= 1'b0;
            r_dmem_be    <= 4'b0000;
        end
    end

    // Load result register; a bus error leaves a clean zero behind.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n)      r_mem_rdata <= '0;
        else if (w_load_done) r_mem_rdata <= w_ld_ext;
        else if (w_tmo_fire)  r_mem_rdata <= '0;
    end

    // Timeout counter runs only while a transaction is outstanding.
    always_ff @(posedge i_aclk or negedge i_areset_n) begin
        if (!i_areset_n)            r_tmo <= '0;
        else if (r_state == S_IDLE) r_tmo <= '0;
        else                        r_tmo <= r_tmo + 1'b1;
    end

    assign o_rdest       = r_rdest;
    assign o_cu_regwrite = r_regwrite;
    assign o_cu_memtoreg = r_memtoreg;
    assign o_exe_calc    = r_exe_calc;
    assign o_pcplus4     = r_pcplus4;
    assign o_mem_rdata   = r_mem_rdata;
    assign o_ma_op       = (r_memtoreg == 2'b10) ? r_pcplus4 : r_exe_calc;
    assign o_stall       = (r_state != S_IDLE);
    assign o_misaligned  = r_misaligned;
    assign o_bus_err     = r_bus_err;
    assign o_dmem_req    = r_dmem_req;
    assign o_dmem_we     = r_dmem_we;
    assign o_dmem_addr   = r_dmem_addr;
    assign o_dmem_wdata  = r_dmem_wdata;
    assign o_dmem_be     = r_dmem_be;

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit: stimulus pushes expected bus
// requests, completions and misalignment pulses; a negedge monitor pops
// and compares whenever the DUT presents the corresponding event.

module tb_memory_access_unit;
    import multicore_pkg::*;

    logic        i_aclk = 1'b0;
    logic        i_areset_n = 1'b0;
    logic        i_en = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_exe_calc = '0;
    logic [31:0] i_exe_wdata = '0;
    logic [31:0] i_pcplus4 = '0;
    logic [4:0]  i_rdest = '0;
    logic        i_cu_regwrite = 1'b0;
    logic        i_cu_memwrite = 1'b0;
    logic        i_cu_memaccess = 1'b0;
    logic [1:0]  i_cu_memtoreg = 2'b00;
    t_ldop       i_ldop = LDOP_LW;
    t_sop        i_sop = SOP_SW;
    logic [4:0]  o_rdest;
    logic        o_cu_regwrite;
    logic [1:0]  o_cu_memtoreg;
    logic [31:0] o_exe_calc, o_pcplus4, o_mem_rdata, o_ma_op;
    logic        o_stall, o_misaligned, o_bus_err;
    logic        o_dmem_req, o_dmem_we;
    logic [31:0] o_dmem_addr, o_dmem_wdata;
    logic [3:0]  o_dmem_be;
    logic        i_dmem_gnt = 1'b0;
    logic        i_dmem_rvalid = 1'b0;
    logic [31:0] i_dmem_rdata = '0;

    memory_access_unit #(.DATA_SIZE(32), .NUM_REGS(32), .TIMEOUT_CYC(8)) dut (
        .i_aclk(i_aclk), .i_areset_n(i_areset_n), .i_en(i_en), .i_flush(i_flush),
        .i_exe_calc(i_exe_calc), .i_exe_wdata(i_exe_wdata), .i_pcplus4(i_pcplus4),
        .i_rdest(i_rdest), .i_cu_regwrite(i_cu_regwrite), .i_cu_memwrite(i_cu_memwrite),
        .i_cu_memaccess(i_cu_memaccess), .i_cu_memtoreg(i_cu_memtoreg),
        .i_ldop(i_ldop), .i_sop(i_sop),
        .o_rdest(o_rdest), .o_cu_regwrite(o_cu_regwrite), .o_cu_memtoreg(o_cu_memtoreg),
        .o_exe_calc(o_exe_calc), .o_pcplus4(o_pcplus4), .o_mem_rdata(o_mem_rdata),
        .o_ma_op(o_ma_op), .o_stall(o_stall), .o_misaligned(o_misaligned),
        .o_bus_err(o_bus_err), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata)
    );

    always #5 i_aclk = ~i_aclk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic        chk_wr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } exp_req_t;

    typedef struct {
        int          stall;
        logic        berr;
        logic        rw;
        logic        chk_rd;
        logic [31:0] rd;
    } exp_cmp_t;

    exp_req_t q_req[$];
    exp_cmp_t q_cmp[$];
    int       q_mis[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic exp_req(input logic [31:0] a, input logic we, input logic cw,
                           input logic [3:0] be, input logic [31:0] wd);
        exp_req_t e;
        e.addr = a; e.we = we; e.chk_wr = cw; e.be = be; e.wdata = wd;
        q_req.push_back(e);
    endtask

    task automatic exp_cmp(input int st, input logic be, input logic rw,
                           input logic cr, input logic [31:0] rd);
        exp_cmp_t e;
        e.stall = st; e.berr = be; e.rw = rw; e.chk_rd = cr; e.rd = rd;
        q_cmp.push_back(e);
    endtask

    // Monitor: compares bus handshakes, misalignment pulses and end-of-stall results.
    int   mon_scnt = 0;
    logic mon_prev = 1'b0;
    always @(negedge i_aclk) begin
        exp_req_t r;
        exp_cmp_t c;
        logic     fell;
        if (!i_areset_n) begin
            mon_scnt = 0;
            mon_prev = 1'b0;
        end else begin
            fell = mon_prev && !o_stall;
            if (o_dmem_req && q_req.size() == 0) chk("req_spurious", 1, 0);
            if (o_dmem_req && i_dmem_gnt && q_req.size() != 0) begin
                r = q_req.pop_front();
                chk("req_addr", o_dmem_addr, r.addr);
                chk("req_we", {31'd0, o_dmem_we}, {31'd0, r.we});
                if (r.chk_wr) begin
                    chk("req_be", {28'd0, o_dmem_be}, {28'd0, r.be});
                    chk("req_wdata", o_dmem_wdata, r.wdata);
                end
            end
            if (o_misaligned) begin
                if (q_mis.size() == 0) chk("mis_spurious", 1, 0);
                else begin
                    void'(q_mis.pop_front());
                    chk("mis_regwrite", {31'd0, o_cu_regwrite}, 0);
                    chk("mis_stall", {31'd0, o_stall}, 0);
                end
            end
            if (o_bus_err && !fell) chk("berr_spurious", 1, 0);
            if (o_stall) mon_scnt++;
            else if (fell) begin
                if (q_cmp.size() == 0) chk("cmp_spurious", 1, 0);
                else begin
                    c = q_cmp.pop_front();
                    chk("stall_len", mon_scnt, c.stall);
                    chk("bus_err", {31'd0, o_bus_err}, {31'd0, c.berr});
                    chk("regwrite", {31'd0, o_cu_regwrite}, {31'd0, c.rw});
                    if (c.chk_rd) chk("rdata", o_mem_rdata, c.rd);
                end
                mon_scnt = 0;
            end
            mon_prev = o_stall;
        end
    end

    task automatic set_in(input logic ma, input logic mw, input logic rw, input logic [1:0] m2r,
                          input t_ldop ld, input t_sop so, input logic [31:0] a, input logic [31:0] wd);
        i_cu_memaccess = ma; i_cu_memwrite = mw; i_cu_regwrite = rw; i_cu_memtoreg = m2r;
        i_ldop = ld; i_sop = so; i_exe_calc = a; i_exe_wdata = wd;
        i_pcplus4 = a + 32'd4; i_rdest = 5'd7;
    endtask

    // Capture one instruction, then play the bus side: grant after gd cycles
    // (gd<0: none), load data after rd further cycles (rd<0: none).
    task automatic do_op(input logic ma, input logic mw, input logic rw, input logic [1:0] m2r,
                         input t_ldop ld, input t_sop so, input logic [31:0] a, input logic [31:0] wd,
                         input int gd, input int rd, input logic [31:0] rdat, input logic rv_early);
        set_in(ma, mw, rw, m2r, ld, so, a, wd);
        i_en = 1'b1;
        @(posedge i_aclk); #1;
        i_en = 1'b0;
        if (gd >= 0) begin
            repeat (gd) begin @(posedge i_aclk); #1; end
            i_dmem_gnt = 1'b1;
            if (rv_early) begin i_dmem_rvalid = 1'b1; i_dmem_rdata = ~rdat; end
            @(posedge i_aclk); #1;
            i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0;
            if (!mw && rd >= 0) begin
                repeat (rd) begin @(posedge i_aclk); #1; end
                i_dmem_rvalid = 1'b1; i_dmem_rdata = rdat;
                @(posedge i_aclk); #1;
                i_dmem_rvalid = 1'b0;
            end
        end
        repeat (3) begin @(posedge i_aclk); #1; end
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge i_aclk);
        chk("rst_stall", {31'd0, o_stall}, 0);
        chk("rst_req", {31'd0, o_dmem_req}, 0);
        chk("rst_regwrite", {31'd0, o_cu_regwrite}, 0);
        chk("rst_be", {28'd0, o_dmem_be}, 0);
        chk("rst_rdata", o_mem_rdata, 0);
        chk("rst_err", {30'd0, o_misaligned, o_bus_err}, 0);
        #2 i_areset_n = 1'b1;
        @(posedge i_aclk); #1;

        // Reset while a request is outstanding drops it at once.
        set_in(1, 0, 1, 2'b01, LDOP_LW, SOP_SW, 32'h0000_0100, 0);
        exp_req(32'h100, 0, 0, 0, 0);
        i_en = 1'b1;
        @(posedge i_aclk); #1;
        i_en = 1'b0;
        @(negedge i_aclk);
        chk("mid_req_on", {31'd0, o_dmem_req}, 1);
        chk("mid_req_addr", o_dmem_addr, 32'h100);
        #2 i_areset_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, o_dmem_req}, 0);
        chk("mid_rst_stall", {31'd0, o_stall}, 0);
        q_req.delete();
        @(negedge i_aclk);
        #2 i_areset_n = 1'b1;
        @(posedge i_aclk); #1;
        @(negedge i_aclk);
        chk("post_rst_stall", {31'd0, o_stall}, 0);
        @(posedge i_aclk); #1;

        // Stores: word with delayed grant, then byte and half lane steering.
        exp_req(32'h1004, 1, 1, 4'b1111, 32'hDEADBEEF); exp_cmp(3, 0, 0, 0, 0);
        do_op(1, 1, 0, 2'b00, LDOP_LW, SOP_SW, 32'h1004, 32'hDEADBEEF, 2, -1, 0, 0);
        exp_req(32'h2000, 1, 1, 4'b1000, 32'hA5A5A5A5); exp_cmp(1, 0, 0, 0, 0);
        do_op(1, 1, 0, 2'b00, LDOP_LW, SOP_SB, 32'h2003, 32'h0000_00A5, 0, -1, 0, 0);
        exp_req(32'h2000, 1, 1, 4'b1100, 32'h12341234); exp_cmp(2, 0, 0, 0, 0);
        do_op(1, 1, 0, 2'b00, LDOP_LW, SOP_SH, 32'h2002, 32'h0000_1234, 1, -1, 0, 0);
        exp_req(32'h2000, 1, 1, 4'b0010, 32'h5A5A5A5A); exp_cmp(1, 0, 0, 0, 0);
        do_op(1, 1, 0, 2'b00, LDOP_LW, SOP_SB, 32'h2001, 32'hFFFF_FF5A, 0, -1, 0, 0);

        // Loads: extraction and extension.
        exp_req(32'h3000, 0, 0, 0, 0); exp_cmp(2, 0, 1, 1, 32'hFFFFFF80);
        do_op(1, 0, 1, 2'b01, LDOP_LB, SOP_SW, 32'h3001, 0, 0, 0, 32'h0000_80FF, 0);
        exp_req(32'h3000, 0, 0, 0, 0); exp_cmp(2, 0, 1, 1, 32'h00000080);
        do_op(1, 0, 1, 2'b01, LDOP_LBU, SOP_SW, 32'h3001, 0, 0, 0, 32'h0000_80FF, 1);
        exp_req(32'h3000, 0, 0, 0, 0); exp_cmp(2, 0, 1, 1, 32'h00008001);
        do_op(1, 0, 1, 2'b01, LDOP_LHU, SOP_SW, 32'h3002, 0, 0, 0, 32'h8001_0000, 0);
        exp_req(32'h3000, 0, 0, 0, 0); exp_cmp(2, 0, 1, 1, 32'hFFFF8001);
        do_op(1, 0, 1, 2'b01, LDOP_LH, SOP_SW, 32'h3002, 0, 0, 0, 32'h8001_0000, 0);
        exp_req(32'h5000, 0, 0, 0, 0); exp_cmp(7, 0, 1, 1, 32'h12345678);
        do_op(1, 0, 1, 2'b01, LDOP_LW, SOP_SW, 32'h5000, 0, 3, 2, 32'h1234_5678, 0);

        // Misaligned accesses: pulse only, no request, no stall.
        q_mis.push_back(1);
        do_op(1, 0, 1, 2'b01, LDOP_LW, SOP_SW, 32'h4002, 0, -1, -1, 0, 0);
        q_mis.push_back(1);
        do_op(1, 0, 1, 2'b01, LDOP_LH, SOP_SW, 32'h4001, 0, -1, -1, 0, 0);
        q_mis.push_back(1);
        do_op(1, 1, 0, 2'b00, LDOP_LW, SOP_SH, 32'h4003, 32'h1, -1, -1, 0, 0);

        // Flushed store is a bubble; ALU ops forward calc or link address.
        set_in(1, 1, 1, 2'b00, LDOP_LW, SOP_SW, 32'h7000, 32'h1);
        i_flush = 1'b1; i_en = 1'b1;
        @(posedge i_aclk); #1;
        i_flush = 1'b0; i_en = 1'b0;
        @(negedge i_aclk);
        chk("flush_regwrite", {31'd0, o_cu_regwrite}, 0);
        chk("flush_stall", {31'd0, o_stall}, 0);
        @(posedge i_aclk); #1;
        set_in(0, 0, 1, 2'b10, LDOP_LW, SOP_SW, 32'h0000_0011, 0);
        i_pcplus4 = 32'h2000_0004; i_en = 1'b1;
        @(posedge i_aclk); #1;
        i_en = 1'b0;
        @(negedge i_aclk);
        chk("maop_pc4", o_ma_op, 32'h2000_0004);
        chk("alu_regwrite", {31'd0, o_cu_regwrite}, 1);
        chk("alu_rdest", {27'd0, o_rdest}, 7);
        @(posedge i_aclk); #1;
        set_in(0, 0, 1, 2'b00, LDOP_LW, SOP_SW, 32'h0000_0033, 0);
        i_en = 1'b1;
        @(posedge i_aclk); #1;
        i_en = 1'b0;
        @(negedge i_aclk);
        chk("maop_calc", o_ma_op, 32'h0000_0033);
        @(posedge i_aclk); #1;

        // Granted load that never returns data times out; a flush mid-stall is ignored.
        exp_req(32'h6000, 0, 0, 0, 0); exp_cmp(8, 1, 0, 1, 32'h0);
        set_in(1, 0, 1, 2'b01, LDOP_LW, SOP_SW, 32'h6000, 0);
        i_en = 1'b1;
        @(posedge i_aclk); #1;
        i_en = 1'b0; i_dmem_gnt = 1'b1;
        @(negedge i_aclk);
        chk("stall_maop", o_ma_op, 32'h6000);
        @(posedge i_aclk); #1;
        i_dmem_gnt = 1'b0;
        @(posedge i_aclk); #1;
        i_en = 1'b1; i_flush = 1'b1;
        repeat (3) begin @(posedge i_aclk); #1; end
        i_en = 1'b0; i_flush = 1'b0;
        repeat (8) begin @(posedge i_aclk); #1; end
        chk("tmo_stall_low", {31'd0, o_stall}, 0);
        chk("tmo_rdata", o_mem_rdata, 0);

        // Every expected event must have been consumed.
        chk("q_req_left", q_req.size(), 0);
        chk("q_cmp_left", q_cmp.size(), 0);
        chk("q_mis_left", q_mis.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/memory_access_unit.md
Name: memory_access_unit

Overview:
- Pipeline stage after execute. Registers the execute-stage results and control.
- Performs data-memory loads/stores over a request/grant/response bus, with byte-lane steering and load sign/zero extension.
- Provides the MA forwarding operand back to execute and a stall to the hazard unit.
- Feeds the write-back stage.

Parameters:
- DATA_SIZE, 32, data/address width (from multicore_pkg).
- NUM_REGS, 32, register count; rdest width is $clog2(NUM_REGS).
- TIMEOUT_CYC, 255, max cycles in REQ+WAIT before bus error.

Ports:
- i_aclk  in  1  clock
- i_areset_n  in  1  async active-low reset
- i_en  in  1  pipeline advance
- i_flush  in  1  capture bubble instead of instruction
- i_exe_calc  in  DATA_SIZE  ALU/system result, also memory address
- i_exe_wdata  in  DATA_SIZE  store data
- i_pcplus4  in  DATA_SIZE  link address
- i_rdest  in  $clog2(NUM_REGS)  destination register
- i_cu_regwrite, i_cu_memwrite, i_cu_memaccess  in  1 each  control
- i_cu_memtoreg  in  2  00 ALU, 01 mem, 10 pc+4
- i_ldop  in  t_ldop  LB/LH/LW/LBU/LHU
- i_sop  in  t_sop  SB/SH/SW
- o_rdest, o_cu_regwrite, o_cu_memtoreg, o_exe_calc, o_pcplus4  out  registered copies for WB
- o_mem_rdata  out  DATA_SIZE  aligned, extended load data
- o_ma_op  out  DATA_SIZE  forward value: o_pcplus4 if memtoreg=10, else o_exe_calc
- o_stall  out  1  transaction outstanding
- o_misaligned  out  1  one-cycle pulse
- o_bus_err  out  1  one-cycle pulse
- o_dmem_req  out  1  request valid
- o_dmem_we  out  1  write
- o_dmem_addr  out  DATA_SIZE  word address, [1:0]=0
- o_dmem_wdata  out  DATA_SIZE  lane-replicated data
- o_dmem_be  out  4  byte enables
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  load data valid
- i_dmem_rdata  in  DATA_SIZE  load data

Behaviour:
- Reset: i_areset_n asynchronous, active-low; clock i_aclk.
  - State IDLE.
  - o_cu_regwrite, o_dmem_req, o_dmem_we, o_stall, o_misaligned, o_bus_err = 0.
  - o_dmem_be = 0, o_mem_rdata = 0, timeout counter = 0.
  - Reset mid-transaction drops o_dmem_req immediately; any in-flight response is ignored.
- Capture happens on a rising edge with i_en=1 and o_stall=0.
  - With i_flush=1, regwrite, memwrite and memaccess are captured as 0.
  - i_flush while o_stall=1 has no effect; the outstanding access completes.
- Alignment check at capture, for memaccess=1:
  - Misaligned if half-word with addr[0]=1, or word with addr[1:0]!=0.
  - On misalignment: no request issued, o_cu_regwrite cleared, o_misaligned high for the next cycle only, state stays IDLE.
- FSM:
  - IDLE→REQ on an aligned memaccess capture.
  - REQ: o_dmem_req=1, address, we, be and wdata held stable until i_dmem_gnt.
    - Gnt on a store→IDLE.
    - Gnt on a load→WAIT.
  - WAIT: on i_dmem_rvalid, latch the extracted data into o_mem_rdata and go to IDLE.
    - rvalid in the same cycle as gnt is not accepted; it must come at least one cycle after gnt.
  - o_stall = (state != IDLE), combinational from the state register.
  - Minimum stall: store 1 cycle, load 2 cycles.
- Timeout:
  - The counter increments each cycle in REQ/WAIT and clears in IDLE.
  - When it reaches TIMEOUT_CYC: go to IDLE, drop req, o_bus_err high for one cycle, o_cu_regwrite cleared, o_mem_rdata = 0.
- Store lanes:
  - SB: be = 1<<addr[1:0], wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - SW: be = 1111.
- Load extraction: shift = 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW passes through.
- o_dmem_* are registered outputs; o_ma_op is valid from the capture cycle onward, including during stall.

Test Plan:
- Reset mid-REQ with req=1, addr 0x100 → req drops asynchronously; after release, stall=0 and state IDLE.
- SW 0xDEADBEEF to 0x1004, gnt after 2 cycles → dmem_addr=0x1004, be=1111, we=1, req held 3 cycles, stall high exactly 3 cycles.
- SB 0x000000A5 to 0x2003 → be=1000, wdata=0xA5A5A5A5; SH 0x1234 to 0x2002 → be=1100, wdata=0x12341234.
- LB from 0x3001 with rdata=0x0000_80FF, gnt immediate, rvalid 1 cycle later → o_mem_rdata=0xFFFFFF80, stall 2 cycles. LBU at the same address → 0x00000080. LHU at 0x3002 with rdata=0x8001_0000 → 0x00008001.
- LW at 0x4002 → no req, o_misaligned one-cycle pulse, o_cu_regwrite=0. LH at 0x4001 → same response.
- Load with gnt but no rvalid, TIMEOUT_CYC=8 → o_bus_err pulses after 8 cycles, stall drops, regwrite=0. A flush asserted during the stall does not abort the access.
